multi_mode_serializer: RTL and testbench

- Parametrised next-generation parallel-to-serial converter for the UART TX path and other serial links in the system.
- Adds the following over the fixed-width LSB-first serializer:
  - a one-entry holding buffer with a valid/ready handshake;
  - runtime frame length and bit order;
  - back-to-back frames with no idle gap;
  - optional parity computation.
- Sits between the TX data source and the TX frame FSM. The FSM supplies the bit tick ser_en and consumes ser_data, ser_done and par_bit.

---
 rtl/multi_mode_serializer_if.sv | 35 +++
 rtl/multi_mode_serializer.sv | 162 ++++++++++++++++
 tb/tb_multi_mode_serializer.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/multi_mode_serializer_if.sv
// multi_mode_serializer_if
//   Groups the data-source handshake, frame configuration and bit-level
//   serial signals of multi_mode_serializer.
//   master : drives P_DATA/DATA_VALID/CFG_*/PAR_TYP/ser_en, observes the rest
//   slave  : the serializer itself
//   Signals:
//     P_DATA[MAX_WIDTH]  parallel word        DATA_VALID / DATA_READY  handshake
//     CFG_LEN[CNT_W]     data bits - 1        CFG_MSB_FIRST, PAR_TYP   frame options
//     ser_en             bit tick             ser_data, ser_active, ser_done, par_bit
interface multi_mode_serializer_if #(
    parameter int MAX_WIDTH = 8,
    parameter int CNT_W     = 3
);
    logic [MAX_WIDTH-1:0] P_DATA;
    logic                 DATA_VALID;
    logic                 DATA_READY;
    logic [CNT_W-1:0]     CFG_LEN;
    logic                 CFG_MSB_FIRST;
    logic                 PAR_TYP;
    logic                 ser_en;
    logic                 ser_data;
    logic                 ser_active;
    logic                 ser_done;
    logic                 par_bit;

    modport master (
        output P_DATA, DATA_VALID, CFG_LEN, CFG_MSB_FIRST, PAR_TYP, ser_en,
        input  DATA_READY, ser_data, ser_active, ser_done, par_bit
    );

    modport slave (
        input  P_DATA, DATA_VALID, CFG_LEN, CFG_MSB_FIRST, PAR_TYP, ser_en,
        output DATA_READY, ser_data, ser_active, ser_done, par_bit
    );
endinterface

// File: rtl/multi_mode_serializer.sv
// multi_mode_serializer
//   Parallel-to-serial converter with a one-entry holding buffer, runtime
//   frame length / bit order and back-to-back frames.
//   Optional parity: define MULTI_MODE_SERIALIZER_PARITY_EN to compute par_bit
//   at load (XOR of data bits [len:0] XOR PAR_TYP); otherwise par_bit = 0.
//   Ports:
//     CLK  system clock (rising edge)
//     RST  asynchronous active-high reset
//     bus  multi_mode_serializer_if.slave (handshake, config, serial outputs)
module multi_mode_serializer #(
    parameter int MAX_WIDTH = 8,
    parameter int CNT_W     = 3
) (
    input  logic                    CLK,
    input  logic                    RST,
    multi_mode_serializer_if.slave  bus
);
    typedef enum logic {IDLE, SHIFT} state_t;

    localparam logic [CNT_W-1:0] LEN_MAX = CNT_W'(MAX_WIDTH - 1);

    state_t               state_q, state_d;
    logic [MAX_WIDTH-1:0] hold_q, hold_d;
    logic [MAX_WIDTH-1:0] data_q, data_d;
    logic                 hold_full_q, hold_full_d;
    logic                 ready_q;
    logic [CNT_W-1:0]     len_q, len_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 msb_q, msb_d;
    logic                 ser_q, ser_d;
    logic                 done_q, done_d;

    logic                 accept;
    logic                 last_tick;
    logic                 load;
    logic [CNT_W-1:0]     cfg_len_c;
    logic [CNT_W-1:0]     cnt_inc;

    // Bit select through a compare loop so the index width never has to
    // match clog2(MAX_WIDTH) exactly.
    function automatic logic bit_at(input logic [MAX_WIDTH-1:0] w,
                                    input logic [CNT_W-1:0]     idx);
        logic b;
        b = 1'b0;
        for (int i = 0; i < MAX_WIDTH; i++)
            if (idx == CNT_W'(i)) b = w[i];
        return b;
    endfunction

    assign accept    = bus.DATA_VALID && ready_q;
    assign last_tick = (state_q == SHIFT) && bus.ser_en && (cnt_q == len_q);
    // Load from IDLE, or straight out of the last tick when a word waits.
    assign load      = hold_full_q && ((state_q == IDLE) || last_tick);
    assign cfg_len_c = (bus.CFG_LEN > LEN_MAX) ? LEN_MAX : bus.CFG_LEN;
    assign cnt_inc   = cnt_q + CNT_W'(1);

    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        data_d      = data_q;
        hold_full_d = hold_full_q;
        len_d       = len_q;
        cnt_d       = cnt_q;
        msb_d       = msb_q;
        ser_d       = ser_q;
        done_d      = 1'b0;

        // accept and load are exclusive: accept needs the buffer empty,
        // load needs it full.
        if (accept) begin
            hold_d      = bus.P_DATA;
            hold_full_d = 1'b1;
        end

        case (state_q)
            SHIFT: begin
                if (bus.ser_en) begin
                    if (cnt_q == len_q) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                        ser_d   = 1'b0;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_inc;
                        ser_d = bit_at(data_q, msb_q ? (len_q - cnt_inc) : cnt_inc);
                    end
                end
            end
            default: ;  // IDLE ignores ser_en
        endcase

        // Load overrides the end-of-frame return to IDLE (back-to-back).
        if (load) begin
            hold_full_d = 1'b0;
            data_d      = hold_q;
            len_d       = cfg_len_c;
            msb_d       = bus.CFG_MSB_FIRST;
            state_d     = SHIFT;
            cnt_d       = '0;
            ser_d       = bit_at(hold_q, bus.CFG_MSB_FIRST ? cfg_len_c : '0);
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= IDLE;
            hold_q      <= '0;
            data_q      <= '0;
            hold_full_q <= 1'b0;
            ready_q     <= 1'b0;
            len_q       <= '0;
            cnt_q       <= '0;
            msb_q       <= 1'b0;
            ser_q       <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            data_q      <= data_d;
            hold_full_q <= hold_full_d;
            // Registered copy of !hold_full so READY stays low during reset
            // and rises on the first edge after release.
            ready_q     <= !hold_full_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            msb_q       <= msb_d;
            ser_q       <= ser_d;
            done_q      <= done_d;
        end
    end

`ifdef MULTI_MODE_SERIALIZER_PARITY_EN
    logic par_q;

    function automatic logic frame_par(input logic [MAX_WIDTH-1:0] w,
                                       input logic [CNT_W-1:0]     len);
        logic p;
        p = 1'b0;
        for (int i = 0; i < MAX_WIDTH; i++)
            if (CNT_W'(i) <= len) p = p ^ w[i];
        return p;
    endfunction

    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            par_q <= 1'b0;
        else if (load)
            par_q <= frame_par(hold_q, cfg_len_c) ^ bus.PAR_TYP;
    end

    assign bus.par_bit = par_q;
`else
    logic unused_par_typ;
    assign unused_par_typ = bus.PAR_TYP;
    assign bus.par_bit    = 1'b0;
`endif

    assign bus.DATA_READY = ready_q;
    assign bus.ser_data   = ser_q;
    assign bus.ser_active = (state_q == SHIFT);
    assign bus.ser_done   = done_q;
endmodule

// File: tb/tb_multi_mode_serializer.sv
// tb_multi_mode_serializer
//   Directed bench for multi_mode_serializer: reset state, LSB/MSB frames,
//   back-to-back frames, parity, asynchronous reset mid-frame and ser_en
//   held high in IDLE and on the load edge.
module tb_multi_mode_serializer;
    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

`ifdef MULTI_MODE_SERIALIZER_PARITY_EN
    localparam bit PE = 1'b1;
`else
    localparam bit PE = 1'b0;
`endif

    multi_mode_serializer_if #(.MAX_WIDTH(8), .CNT_W(3)) bus ();

    multi_mode_serializer #(.MAX_WIDTH(8), .CNT_W(3)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic tick();
        bus.ser_en = 1'b1;
        step();
        bus.ser_en = 1'b0;
    endtask

    task automatic send(input logic [7:0] w, input logic [2:0] len,
                        input logic msb, input logic pt);
        int n;
        n = 0;
        while (!bus.DATA_READY && n < 50) begin
            step();
            n++;
        end
        if (!bus.DATA_READY) chk("rdy_timeout", bus.DATA_READY, 1);
        bus.P_DATA        = w;
        bus.CFG_LEN       = len;
        bus.CFG_MSB_FIRST = msb;
        bus.PAR_TYP       = pt;
        bus.DATA_VALID    = 1'b1;
        step();
        bus.DATA_VALID    = 1'b0;
    endtask

    // seq[i] is the i-th emitted bit; checks each bit and the done pulse.
    task automatic play(input string tag, input logic [7:0] seq, input int n);
        for (int i = 0; i < n; i++) begin
            chk({tag, "_bit"}, bus.ser_data, seq[i]);
            chk({tag, "_act"}, bus.ser_active, 1);
            tick();
            chk({tag, "_done"}, bus.ser_done, (i == n - 1));
        end
    endtask

    initial begin
        bus.P_DATA        = '0;
        bus.DATA_VALID    = 1'b0;
        bus.CFG_LEN       = '0;
        bus.CFG_MSB_FIRST = 1'b0;
        bus.PAR_TYP       = 1'b0;
        bus.ser_en        = 1'b0;

        // reset state
        #12;
        chk("rst_data", bus.ser_data, 0);
        chk("rst_act", bus.ser_active, 0);
        chk("rst_done", bus.ser_done, 0);
        chk("rst_par", bus.par_bit, 0);
        chk("rst_rdy", bus.DATA_READY, 0);
        RST = 1'b0;
        #1;
        chk("rdy_pre_edge", bus.DATA_READY, 0);
        step();
        chk("rdy_after_rel", bus.DATA_READY, 1);

        // 0xA5, 8 bits LSB first: 1,0,1,0,0,1,0,1
        send(8'hA5, 3'd7, 1'b0, 1'b0);
        chk("a5_rdy_full", bus.DATA_READY, 0);
        chk("a5_act_n", bus.ser_active, 0);
        step();
        chk("a5_act_n1", bus.ser_active, 1);
        chk("a5_rdy_n1", bus.DATA_READY, 1);
        play("a5lsb", 8'b1010_0101, 8);
        chk("a5_idle_act", bus.ser_active, 0);
        chk("a5_idle_data", bus.ser_data, 0);
        chk("a5_idle_rdy", bus.DATA_READY, 1);
        step();
        chk("a5_done_one", bus.ser_done, 0);

        // 0xA5, 5 bits MSB first: bits 4..0 = 0,0,1,0,1
        send(8'hA5, 3'd4, 1'b1, 1'b0);
        step();
        play("a5msb", 8'b0001_0100, 5);
        chk("a5msb_idle", bus.ser_active, 0);
        chk("a5msb_data0", bus.ser_data, 0);

        // back-to-back 0x0F then 0xF0
        send(8'h0F, 3'd7, 1'b0, 1'b0);
        step();
        send(8'hF0, 3'd7, 1'b0, 1'b0);
        chk("b2b_rdy0", bus.DATA_READY, 0);
        play("b2b_0f", 8'h0F, 8);
        chk("b2b_act", bus.ser_active, 1);
        chk("b2b_data", bus.ser_data, 0);
        chk("b2b_rdy1", bus.DATA_READY, 1);
        play("b2b_f0", 8'hF0, 8);
        chk("b2b_end", bus.ser_active, 0);

        // parity
        send(8'h07, 3'd7, 1'b0, 1'b0);
        step();
        chk("par_even8", bus.par_bit, PE ? 1 : 0);
        play("par1", 8'h07, 8);
        chk("par_hold", bus.par_bit, PE ? 1 : 0);
        send(8'h07, 3'd7, 1'b0, 1'b1);
        step();
        chk("par_odd8", bus.par_bit, 0);
        play("par2", 8'h07, 8);
        send(8'h07, 3'd1, 1'b0, 1'b0);
        step();
        chk("par_even2", bus.par_bit, 0);
        play("par3", 8'h03, 2);

        // async reset on the 3rd tick with a word buffered
        send(8'hA5, 3'd7, 1'b0, 1'b0);
        step();
        tick();
        tick();
        chk("mid_data", bus.ser_data, 1);
        send(8'h3C, 3'd7, 1'b0, 1'b0);
        chk("mid_rdy0", bus.DATA_READY, 0);
        bus.ser_en = 1'b1;
        #3;
        RST = 1'b1;
        #1;
        chk("ar_data", bus.ser_data, 0);
        chk("ar_act", bus.ser_active, 0);
        chk("ar_done", bus.ser_done, 0);
        chk("ar_par", bus.par_bit, 0);
        chk("ar_rdy", bus.DATA_READY, 0);
        step();
        chk("ar_done_edge", bus.ser_done, 0);
        RST = 1'b0;
        bus.ser_en = 1'b0;
        step();
        chk("ar_rel_rdy", bus.DATA_READY, 1);
        chk("ar_rel_act", bus.ser_active, 0);
        step();
        chk("ar_discard", bus.ser_active, 0);

        // ser_en held high in IDLE and on the load edge
        bus.ser_en = 1'b1;
        step();
        step();
        chk("en_idle_act", bus.ser_active, 0);
        chk("en_idle_data", bus.ser_data, 0);
        send(8'hA5, 3'd7, 1'b0, 1'b0);
        step();
        chk("en_load_act", bus.ser_active, 1);
        chk("en_load_bit", bus.ser_data, 1);
        bus.ser_en = 1'b0;
        step();
        chk("en_hold_bit", bus.ser_data, 1);
        play("en_a5", 8'b1010_0101, 8);
        chk("en_end", bus.ser_active, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
